// File: rtl/shift_rnd_lanes.sv
// Multi-lane pipelined shift/round/saturate: signed width_i -> signed width_o per lane, two stages.
// Define SHIFT_RND_SAT_FLAG_EN to add the per-lane o_sat saturation flag port.
`timescale 1ns/1ps

module shift_rnd_lanes #(
  parameter int lanes       = 4,
  parameter int width_i     = 9,
  parameter int width_o     = 8,
  parameter int width_shift = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [lanes*width_i-1:0]       i_num,
  input  logic [lanes*width_shift-1:0]   i_shift,
  input  logic [1:0]                     i_mode,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [lanes*width_o-1:0]       o_rnd
`ifdef SHIFT_RND_SAT_FLAG_EN
  ,
  output logic [lanes-1:0]               o_sat
`endif
);

  localparam int width_x = 2 * width_i;
  localparam logic [width_shift:0] t_off = (width_shift + 1)'(width_i - width_o);
  // Any shift beyond width_i+1 behaves identically: floor is all sign, guard is sign, sticky is |num.
  localparam logic [width_shift:0] t_cap = (width_shift + 1)'(width_i + 1);
  localparam logic signed [width_i:0] sat_hi = (width_i + 1)'(2 ** (width_o - 1) - 1);
  localparam logic signed [width_i:0] sat_lo = (width_i + 1)'(-(2 ** (width_o - 1)));

  localparam logic [1:0] mode_rne = 2'd0;
  localparam logic [1:0] mode_rtz = 2'd1;
  localparam logic [1:0] mode_rdn = 2'd2;

  logic s1_v, s2_v, s2_load;

  logic signed [width_i-1:0] floor_c [lanes];
  logic [lanes-1:0]          guard_c, sticky_c;
  logic [width_o-1:0]        rnd_c [lanes];

  logic signed [width_i-1:0] s1_floor [lanes];
  logic [lanes-1:0]          s1_guard, s1_sticky;
  logic [1:0]                s1_mode;

`ifdef SHIFT_RND_SAT_FLAG_EN
  logic [lanes-1:0] sat_c;
`endif

  assign s2_load = !s2_v || i_ready;
  assign o_ready = !s1_v || s2_load;
  assign o_valid = s2_v;

  for (genvar k = 0; k < lanes; k++) begin : g_s1
    logic signed [width_x-1:0] ext;
    logic [width_shift:0]      t, tc;
    logic [width_x-1:0]        gmask;

    assign ext   = width_x'(signed'(i_num[k*width_i +: width_i]));
    assign t     = {1'b0, i_shift[k*width_shift +: width_shift]} + t_off;
    assign tc    = (t > t_cap) ? t_cap : t;
    assign gmask = (tc == '0) ? '0 : (width_x'(1) << (tc - 1'b1));

    assign floor_c[k]  = width_i'(ext >>> tc);
    assign guard_c[k]  = |(ext & gmask);
    assign sticky_c[k] = (tc != '0) && |(ext & (gmask - 1'b1));
  end

  for (genvar k = 0; k < lanes; k++) begin : g_s2
    logic                    neg, inc, hi, lo;
    logic signed [width_i:0] sum;

    // The floor keeps the sign of the input, so its MSB doubles as the sign bit.
    assign neg = s1_floor[k][width_i-1];

    always_comb begin
      inc = 1'b0;
      case (s1_mode)
        mode_rne: inc = s1_guard[k] && (s1_sticky[k] || s1_floor[k][0]);
        mode_rtz: inc = neg && (s1_guard[k] || s1_sticky[k]);
        mode_rdn: inc = 1'b0;
        default:  inc = s1_guard[k] && (!neg || s1_sticky[k]);
      endcase
    end

    assign sum      = {s1_floor[k][width_i-1], s1_floor[k]} + (width_i + 1)'(inc);
    assign hi       = sum > sat_hi;
    assign lo       = sum < sat_lo;
    assign rnd_c[k] = hi ? sat_hi[width_o-1:0] : (lo ? sat_lo[width_o-1:0] : sum[width_o-1:0]);

`ifdef SHIFT_RND_SAT_FLAG_EN
    assign sat_c[k] = hi || lo;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: data registers are reset too so o_rnd reads 0 during reset, not just o_valid.
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s1_mode   <= '0;
      s1_guard  <= '0;
      s1_sticky <= '0;
      o_rnd     <= '0;
      for (int k = 0; k < lanes; k++) s1_floor[k] <= '0;
`ifdef SHIFT_RND_SAT_FLAG_EN
      o_sat     <= '0;
`endif
    end else begin
      if (o_ready) begin
        s1_v <= i_valid;
        if (i_valid) begin
          s1_mode   <= i_mode;
          s1_guard  <= guard_c;
          s1_sticky <= sticky_c;
          for (int k = 0; k < lanes; k++) s1_floor[k] <= floor_c[k];
        end
      end
      if (s2_load) begin
        s2_v <= s1_v;
        if (s1_v) begin
          for (int k = 0; k < lanes; k++) o_rnd[k*width_o +: width_o] <= rnd_c[k];
`ifdef SHIFT_RND_SAT_FLAG_EN
          o_sat <= sat_c;
`endif
        end
      end
    end
  end

endmodule
